// File: rtl/sample_stream_tx_pkg.sv
// sample_stream_tx_pkg: shared types and constants for the sample stream
// transmitter and the testbenches that drive it.
//   DEF_DATA_WIDTH    - default sample width (Q1.15 signed)
//   SAMPLE_WORD_WIDTH - width of a packed two-sample host word
//   tx_state_e        - transmitter frame state
//   sample_word_t     - packed host word, low half = first sample
package sample_stream_tx_pkg;

  localparam int DEF_DATA_WIDTH    = 16;
  localparam int SAMPLE_WORD_WIDTH = 2 * DEF_DATA_WIDTH;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_RUN,
    TX_DONE
  } tx_state_e;

  typedef logic [SAMPLE_WORD_WIDTH-1:0] sample_word_t;

endpackage : sample_stream_tx_pkg

// File: rtl/stream_fifo.sv
// stream_fifo: synchronous show-ahead FIFO, parameterised width and depth.
// DEPTH must be a power of two (pointers wrap naturally) and at least 2.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset (contents cleared)
//   push, din  - write request and data; ignored while full
//   pop        - remove the head word; ignored while empty
//   dout       - current head word (valid while !empty)
//   level      - number of stored words, 0..DEPTH
//   full/empty - decoded from the registered level
module stream_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push_ok, pop_ok;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path can
    // leave a signal unassigned and infer a latch.
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Simultaneous push and pop leave the level unchanged.
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the storage array is reset as well, so stale words can never
      // reappear at dout after a reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule : stream_fifo

// File: rtl/sample_stream_tx.sv
// sample_stream_tx: buffers packed two-sample host words in a FIFO and
// transmits exactly FRAME_LEN signed samples per start command over a
// valid/ready stream (low half of each word first, then the high half).
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   wr_en        - host write strobe; wr_data = {second, first} sample
//   wr_full      - FIFO full, writes dropped while high
//   fifo_level   - words currently buffered
//   start        - single-cycle frame start (honoured only in IDLE)
//   out_valid/out_ready/out_data/out_last - registered sample stream
//   busy         - frame in progress
//   frame_done   - one-cycle pulse after the last transfer
//   overflow     - sticky dropped-write flag, cleared by start
//   stall_cycles - saturating count of RUN cycles with out_valid low
module sample_stream_tx
  import sample_stream_tx_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH  = 16,
  parameter int FRAME_LEN   = 64,
  parameter int STALL_CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic [2*DATA_WIDTH-1:0]     wr_data,
  output logic                        wr_full,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  input  logic                        start,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_last,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        overflow,
  output logic [STALL_CNT_W-1:0]      stall_cycles
);

  localparam int                CNT_W     = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0]  FRAME_CNT = CNT_W'(FRAME_LEN);

  tx_state_e                 state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;        // samples loaded this frame
  logic                      half_q, half_d;      // 0: low half next, 1: high
  logic                      out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]     out_data_q, out_data_d;
  logic                      out_last_q, out_last_d;
  logic                      overflow_q, overflow_d;
  logic [STALL_CNT_W-1:0]    stall_q, stall_d;

  logic [2*DATA_WIDTH-1:0]   fifo_head;
  logic                      fifo_empty, fifo_full, fifo_pop;
  logic                      start_accept, transfer, load, last_load;
  logic [CNT_W-1:0]          cnt_base;

  stream_fifo #(
    .WIDTH (2 * DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_en),
    .pop   (fifo_pop),
    .din   (wr_data),
    .dout  (fifo_head),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    half_d      = half_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    overflow_d  = overflow_q;
    stall_d     = stall_q;

    start_accept = (state_q == TX_IDLE) && start;
    transfer     = out_valid_q && out_ready;

    // The start cycle is already a load opportunity, counted from zero, so a
    // prefilled FIFO presents its first sample without a bubble.
    cnt_base  = start_accept ? '0 : cnt_q;
    last_load = (cnt_base == LAST_IDX);
    load      = ((state_q == TX_RUN) || start_accept) &&
                (!out_valid_q || transfer) && !fifo_empty &&
                (cnt_base != FRAME_CNT);
    // Pop on the high half, or on the final sample of an odd-length frame
    // (the unused high half of that word is discarded).
    fifo_pop  = load && (half_q || last_load);

    case (state_q)
      TX_IDLE: if (start) state_d = TX_RUN;
      TX_RUN:  if (transfer && out_last_q) state_d = TX_DONE;
      TX_DONE: state_d = TX_IDLE;
      default: state_d = TX_IDLE;
    endcase

    if (start_accept) begin
      cnt_d   = '0;
      stall_d = '0;
    end

    if (load) begin
      cnt_d       = cnt_base + 1'b1;
      half_d      = last_load ? 1'b0 : !half_q;
      out_data_d  = half_q ? fifo_head[2*DATA_WIDTH-1:DATA_WIDTH]
                           : fifo_head[DATA_WIDTH-1:0];
      out_last_d  = last_load;
      out_valid_d = 1'b1;
    end else if (transfer) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    if ((state_q == TX_RUN) && !out_valid_q && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end

    if (start_accept) overflow_d = 1'b0;
    if (wr_en && fifo_full) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= TX_IDLE;
      cnt_q       <= '0;
      half_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      overflow_q  <= 1'b0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      half_q      <= half_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      overflow_q  <= overflow_d;
      stall_q     <= stall_d;
    end
  end

  assign wr_full      = fifo_full;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_last     = out_last_q;
  assign busy         = (state_q == TX_RUN);
  assign frame_done   = (state_q == TX_DONE);
  assign overflow     = overflow_q;
  assign stall_cycles = stall_q;

endmodule : sample_stream_tx

// File: tb/tb_sample_stream_tx.sv
// tb_sample_stream_tx: drives a 64-sample and a 5-sample transmitter (sel
// picks which one receives stimulus and is observed) and compares every
// transferred sample against a queue model of the word FIFO.
module tb_sample_stream_tx;
  import sample_stream_tx_pkg::*;

  localparam int DW        = DEF_DATA_WIDTH;
  localparam int DEPTH     = 16;
  localparam int LW        = $clog2(DEPTH) + 1;
  localparam int SCW       = 16;
  localparam int LONG_LEN  = 64;
  localparam int SHORT_LEN = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         sel = 1'b0;
  logic         wr_en = 1'b0;
  logic         start = 1'b0;
  logic         out_ready = 1'b0;
  sample_word_t wr_data = '0;

  logic           wr_full_v    [2];
  logic [LW-1:0]  fifo_level_v [2];
  logic           out_valid_v  [2];
  logic [DW-1:0]  out_data_v   [2];
  logic           out_last_v   [2];
  logic           busy_v       [2];
  logic           frame_done_v [2];
  logic           overflow_v   [2];
  logic [SCW-1:0] stall_v      [2];

  logic           wr_full, out_valid, out_last, busy, frame_done, overflow;
  logic [LW-1:0]  fifo_level;
  logic [DW-1:0]  out_data;
  logic [SCW-1:0] stall_cycles;

  assign wr_full      = wr_full_v[sel];
  assign fifo_level   = fifo_level_v[sel];
  assign out_valid    = out_valid_v[sel];
  assign out_data     = out_data_v[sel];
  assign out_last     = out_last_v[sel];
  assign busy         = busy_v[sel];
  assign frame_done   = frame_done_v[sel];
  assign overflow     = overflow_v[sel];
  assign stall_cycles = stall_v[sel];

  always #5 clk = ~clk;

  sample_stream_tx #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FRAME_LEN(LONG_LEN), .STALL_CNT_W(SCW)
  ) u_long (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en && !sel), .wr_data(wr_data),
    .wr_full(wr_full_v[0]), .fifo_level(fifo_level_v[0]), .start(start && !sel),
    .out_valid(out_valid_v[0]), .out_ready(out_ready), .out_data(out_data_v[0]),
    .out_last(out_last_v[0]), .busy(busy_v[0]), .frame_done(frame_done_v[0]),
    .overflow(overflow_v[0]), .stall_cycles(stall_v[0])
  );

  sample_stream_tx #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FRAME_LEN(SHORT_LEN), .STALL_CNT_W(SCW)
  ) u_short (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en && sel), .wr_data(wr_data),
    .wr_full(wr_full_v[1]), .fifo_level(fifo_level_v[1]), .start(start && sel),
    .out_valid(out_valid_v[1]), .out_ready(out_ready), .out_data(out_data_v[1]),
    .out_last(out_last_v[1]), .busy(busy_v[1]), .frame_done(frame_done_v[1]),
    .overflow(overflow_v[1]), .stall_cycles(stall_v[1])
  );

  int           tests = 0;
  int           fails = 0;
  sample_word_t stim_q[$];   // words still to be written during a frame
  sample_word_t model_q[$];  // words the FIFO should hold, head first
  bit           model_ovf;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic sample_word_t pat_word(input int i);
    return {DW'(2 * i + 2), DW'(2 * i + 1)};
  endfunction

  task automatic reset_dut();
    wr_en = 1'b0; start = 1'b0; out_ready = 1'b0; wr_data = '0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    model_q.delete();
    stim_q.delete();
    model_ovf = 1'b0;
  endtask

  // Writes while the transmitter is idle: no pops, so the model decides
  // acceptance from its own occupancy.
  task automatic prefill(input sample_word_t w);
    wr_en = 1'b1;
    wr_data = w;
    if (model_q.size() < DEPTH) model_q.push_back(w);
    else model_ovf = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  // Runs one frame: optional start pulse, then streams stim_q in as space
  // allows while draining with always-ready or random out_ready.
  task automatic run_frame(input int frame_len, input bit rand_ready,
                           input bit do_start, input int stop_after,
                           input int exp_stall, input string tag);
    logic [DW-1:0] got_d[$];
    bit            got_l[$];
    logic [DW-1:0] exp_d[$];
    bit            hold = 1'b0;
    logic [DW-1:0] hold_d = '0;
    logic          hold_l = 1'b0;
    bit            exp_done = 1'b0;
    bit            done_seen = 1'b0;
    bit            half = 1'b0;
    int            cyc = 0;
    int            n_exp;

    if (do_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      model_ovf = 1'b0;
      tests++;
      if (busy !== 1'b1 || overflow !== 1'b0 || out_valid !== (model_q.size() > 0)) begin
        fails++;
        $display("FAIL %s start: busy=%b ovf=%b valid=%b required busy=1 ovf=0 valid=%b",
                 tag, busy, overflow, out_valid, model_q.size() > 0);
      end
    end

    while (!done_seen && cyc < 3000) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      wr_en = 1'b0;
      if (stim_q.size() > 0 && !wr_full) begin
        wr_en = 1'b1;
        wr_data = stim_q[0];
      end
      if (hold) begin
        tests++;
        if (out_valid !== 1'b1 || out_data !== hold_d || out_last !== hold_l) begin
          fails++;
          $display("FAIL %s hold: valid=%b data=%h last=%b required valid=1 data=%h last=%b",
                   tag, out_valid, out_data, out_last, hold_d, hold_l);
        end
      end
      hold   = out_valid && !out_ready;
      hold_d = out_data;
      hold_l = out_last;
      if (out_valid === 1'b1 && out_ready) begin
        got_d.push_back(out_data);
        got_l.push_back(out_last === 1'b1);
        exp_done = (out_last === 1'b1);
      end
      if (wr_en) model_q.push_back(stim_q.pop_front());
      tick();
      cyc++;
      wr_en = 1'b0;
      if (exp_done) begin
        done_seen = 1'b1;
        tests++;
        if (frame_done !== 1'b1 || busy !== 1'b0) begin
          fails++;
          $display("FAIL %s done pulse: frame_done=%b busy=%b required 1/0", tag, frame_done, busy);
        end
      end else if (frame_done !== 1'b0) begin
        tests++;
        fails++;
        $display("FAIL %s early done: frame_done=%b required 0", tag, frame_done);
      end
      if (stop_after > 0 && got_d.size() >= stop_after) break;
    end

    if (stop_after == 0) begin
      tests++;
      if (!done_seen) begin
        fails++;
        $display("FAIL %s timeout: %0d beats after %0d cycles, required %0d", tag, got_d.size(), cyc, frame_len);
      end else begin
        tick();
        if (frame_done !== 1'b0 || out_valid !== 1'b0) begin
          fails++;
          $display("FAIL %s done length: frame_done=%b valid=%b required 0/0", tag, frame_done, out_valid);
        end
      end
    end

    // Reference: low half then high half of each word; the final sample pops
    // its word and the next frame starts on a low half again.
    n_exp = (stop_after > 0) ? got_d.size() : frame_len;
    for (int i = 0; i < n_exp && model_q.size() > 0; i++) begin
      exp_d.push_back(half ? model_q[0][2*DW-1:DW] : model_q[0][DW-1:0]);
      if (half || i == frame_len - 1) void'(model_q.pop_front());
      half = (i == frame_len - 1) ? 1'b0 : !half;
    end

    tests++;
    if (got_d.size() != n_exp || exp_d.size() != n_exp) begin
      fails++;
      $display("FAIL %s beat count: got %0d required %0d", tag, got_d.size(), n_exp);
    end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      tests++;
      if (got_d[i] !== exp_d[i] || got_l[i] != (i == frame_len - 1)) begin
        fails++;
        $display("FAIL %s beat %0d: data=%h last=%b required data=%h last=%b",
                 tag, i, got_d[i], got_l[i], exp_d[i], i == frame_len - 1);
      end
    end

    if (stop_after == 0) begin
      tests++;
      if (fifo_level !== LW'(model_q.size()) || overflow !== model_ovf) begin
        fails++;
        $display("FAIL %s end state: level=%0d ovf=%b required level=%0d ovf=%b",
                 tag, fifo_level, overflow, model_q.size(), model_ovf);
      end
      if (exp_stall >= 0) begin
        tests++;
        if (stall_cycles !== SCW'(exp_stall)) begin
          fails++;
          $display("FAIL %s stall count: got %0d required %0d", tag, stall_cycles, exp_stall);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset_dut();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      tests++;
      if ({out_valid, out_last, busy, frame_done, overflow, wr_full} !== 6'b0) begin
        fails++;
        $display("FAIL reset flags dut%0d: valid/last/busy/done/ovf/full=%b required 000000", s,
                 {out_valid, out_last, busy, frame_done, overflow, wr_full});
      end
      tests++;
      if (out_data !== '0 || stall_cycles !== '0 || fifo_level !== '0) begin
        fails++;
        $display("FAIL reset values dut%0d: data=%h stall=%0d level=%0d required 0/0/0", s,
                 out_data, stall_cycles, fifo_level);
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_full_frame();
    sel = 1'b0;
    reset_dut();
    for (int i = 0; i < DEPTH; i++) prefill(pat_word(i));
    for (int i = DEPTH; i < 32; i++) stim_q.push_back(pat_word(i));
    run_frame(LONG_LEN, 1'b0, 1'b1, 0, 0, "full_frame");
  endtask

  task automatic test_backpressure();
    sel = 1'b0;
    reset_dut();
    for (int i = 0; i < DEPTH; i++) prefill(pat_word(i));
    for (int i = DEPTH; i < 32; i++) stim_q.push_back(pat_word(i));
    run_frame(LONG_LEN, 1'b1, 1'b1, 0, 0, "backpressure_pattern");
    for (int i = 0; i < DEPTH; i++) prefill(sample_word_t'($urandom));
    for (int i = 0; i < 16; i++) stim_q.push_back(sample_word_t'($urandom));
    run_frame(LONG_LEN, 1'b1, 1'b1, 0, 0, "backpressure_random");
  endtask

  task automatic test_stall();
    sel = 1'b0;
    reset_dut();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    tests++;
    if (stall_cycles !== SCW'(9) || out_valid !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL stall empty run: stall=%0d valid=%b busy=%b required 9/0/1", stall_cycles, out_valid, busy);
    end
    wr_en = 1'b1;
    wr_data = pat_word(0);
    model_q.push_back(pat_word(0));
    tick();
    wr_en = 1'b0;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL stall write edge valid: got %b required 0", out_valid);
    end
    tick();
    tests++;
    if (out_valid !== 1'b1 || out_data !== DW'(1) || stall_cycles !== SCW'(11)) begin
      fails++;
      $display("FAIL stall first beat: valid=%b data=%h stall=%0d required 1/0001/11", out_valid, out_data, stall_cycles);
    end
    for (int i = 1; i < 32; i++) stim_q.push_back(pat_word(i));
    run_frame(LONG_LEN, 1'b0, 1'b0, 0, 11, "stall_frame");
  endtask

  task automatic test_overflow();
    sel = 1'b0;
    reset_dut();
    for (int i = 0; i < DEPTH - 1; i++) prefill(sample_word_t'($urandom));
    tests++;
    if (wr_full !== 1'b0 || fifo_level !== LW'(DEPTH - 1)) begin
      fails++;
      $display("FAIL overflow level15: full=%b level=%0d required 0/15", wr_full, fifo_level);
    end
    for (int i = 0; i < 4; i++) prefill(sample_word_t'($urandom));
    tests++;
    if (wr_full !== 1'b1 || fifo_level !== LW'(DEPTH) || overflow !== model_ovf) begin
      fails++;
      $display("FAIL overflow full: full=%b level=%0d ovf=%b required 1/16/%b", wr_full, fifo_level, overflow, model_ovf);
    end
    for (int i = 0; i < 16; i++) stim_q.push_back(sample_word_t'($urandom));
    run_frame(LONG_LEN, 1'b0, 1'b1, 0, 0, "overflow_frame");
  endtask

  task automatic test_odd_frame();
    sel = 1'b1;
    reset_dut();
    for (int i = 0; i < 4; i++) prefill(pat_word(i));
    run_frame(SHORT_LEN, 1'b0, 1'b1, 0, 0, "odd_first");
    for (int i = 0; i < 2; i++) stim_q.push_back(sample_word_t'($urandom));
    run_frame(SHORT_LEN, 1'b0, 1'b1, 0, 0, "odd_second");
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 3; i++) prefill(sample_word_t'($urandom));
      run_frame(SHORT_LEN, 1'b1, 1'b1, 0, 0, "odd_random");
    end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    sel = 1'b0;
    reset_dut();
    for (int i = 0; i < DEPTH; i++) prefill(pat_word(i));
    for (int i = DEPTH; i < 32; i++) stim_q.push_back(pat_word(i));
    run_frame(LONG_LEN, 1'b0, 1'b1, 20, -1, "mid_frame");
    rst_n = 1'b0;
    #1;
    tests++;
    if ({out_valid, out_last, busy, frame_done, overflow, wr_full} !== 6'b0 ||
        out_data !== '0 || fifo_level !== '0 || stall_cycles !== '0) begin
      fails++;
      $display("FAIL async reset: flags=%b data=%h level=%0d stall=%0d required all zero",
               {out_valid, out_last, busy, frame_done, overflow, wr_full}, out_data, fifo_level, stall_cycles);
    end
    repeat (3) begin
      tick();
      tests++;
      if (frame_done !== 1'b0) begin
        fails++;
        $display("FAIL reset frame_done: got %b required 0", frame_done);
      end
    end
    rst_n = 1'b1;
    model_q.delete();
    stim_q.delete();
    tick();
    tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || fifo_level !== '0 || frame_done !== 1'b0) begin
      fails++;
      $display("FAIL after reset: busy=%b valid=%b level=%0d done=%b required 0/0/0/0",
               busy, out_valid, fifo_level, frame_done);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_full_frame();
    test_backpressure();
    test_stall();
    test_overflow();
    test_odd_frame();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_sample_stream_tx
